// File: rtl/eda_output_reader.sv
// Streams a snapshot of the M x N flag matrix row-major, BEAT_WIDTH bits per beat.
// Latency: first beat is valid the cycle after start; one beat per cycle with a ready sink.
// Backpressure: beats hold stable while out_ready is low. ones_count needs EDA_OUT_READER_COUNT_EN.
`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 5
`endif

module eda_output_reader #(
    parameter int M          = `CFG_M,
    parameter int N          = `CFG_N,
    parameter int BEAT_WIDTH = 8,
    localparam int MN         = M * N,
    localparam int NUM_BEATS  = (MN + BEAT_WIDTH - 1) / BEAT_WIDTH,
    localparam int BEAT_IDX_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1,
    localparam int CNT_W      = $clog2(MN + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [MN-1:0]         matrix_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BEAT_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [BEAT_IDX_W-1:0] out_index,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      ones_count
);

    localparam int TOT = NUM_BEATS * BEAT_WIDTH;
    localparam logic [BEAT_IDX_W-1:0] LAST_IDX = BEAT_IDX_W'(NUM_BEATS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t state, state_n;
    logic [MN-1:0]         snap;
    logic [BEAT_IDX_W-1:0] next_idx;
    logic                  load, fire, finish;

    // Bits past the end of the matrix read as zero, which pads the last beat.
    function automatic logic [BEAT_WIDTH-1:0] beat_of(input logic [MN-1:0] v,
                                                      input logic [BEAT_IDX_W-1:0] k);
        logic [TOT-1:0] p;
        p = '0;
        p[MN-1:0] = v;
        return p[k*BEAT_WIDTH +: BEAT_WIDTH];
    endfunction

    assign out_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    assign next_idx  = out_index + BEAT_IDX_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        fire    = 1'b0;
        finish  = 1'b0;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n = STREAM;
                        load    = 1'b1;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        fire = 1'b1;
                        if (out_last) begin
                            state_n = IDLE;
                            finish  = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap      <= '1;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= finish;
            if (abort) begin
                out_last <= 1'b0;
            end else if (load) begin
                snap      <= matrix_in;
                out_index <= '0;
                out_data  <= beat_of(matrix_in, '0);
                out_last  <= (NUM_BEATS == 1);
            end else if (fire) begin
                if (out_last) begin
                    out_last <= 1'b0;
                    out_data <= '0;
                end else begin
                    out_index <= next_idx;
                    out_data  <= beat_of(snap, next_idx);
                    out_last  <= (next_idx == LAST_IDX);
                end
            end
        end
    end

`ifdef EDA_OUT_READER_COUNT_EN
    function automatic logic [CNT_W-1:0] popcount(input logic [BEAT_WIDTH-1:0] b);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int t = 0; t < BEAT_WIDTH; t++) s = s + CNT_W'(b[t]);
        return s;
    endfunction

    // Padding bits are zero, so counting whole beats never over-counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  ones_count <= '0;
        else if (load) ones_count <= '0;
        else if (fire) ones_count <= ones_count + popcount(out_data);
    end
`else
    assign ones_count = '0;
`endif

endmodule

// File: tb/tb_eda_output_reader.sv
// Randomised and directed bench for eda_output_reader (M=4, N=5, BEAT_WIDTH=8).
module tb_eda_output_reader;
    localparam int MN = 20;
    localparam int NB = 3;

    logic        clk = 1'b0;
    logic        reset_n, start, abort, out_ready;
    logic [19:0] matrix_in;
    logic        out_valid, out_last, busy, done;
    logic [7:0]  out_data;
    logic [1:0]  out_index;
    logic [4:0]  ones_count;

    eda_output_reader #(.M(4), .N(5), .BEAT_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .matrix_in(matrix_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .out_index(out_index),
        .busy(busy), .done(done), .ones_count(ones_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of beats cut from the snapshot.
    bit         m_active = 0;
    bit         m_done = 0;
    int         m_pos = 0;
    int         m_ones = 0;
    logic [7:0] m_beats [NB];
    logic [7:0] acc_q [$];

    function automatic logic [7:0] beat_ref(input logic [19:0] v, input int k);
        logic [7:0] b;
        for (int t = 0; t < 8; t++) begin
            int idx;
            idx = k * 8 + t;
            b[t] = (idx < MN) ? v[idx] : 1'b0;
        end
        return b;
    endfunction

    function automatic int pop8(input logic [7:0] b);
        int s;
        s = 0;
        for (int t = 0; t < 8; t++) s += int'(b[t]);
        return s;
    endfunction

    function automatic int exp_ones();
`ifdef EDA_OUT_READER_COUNT_EN
        return m_ones;
`else
        return 0;
`endif
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0; m_done = 0; m_pos = 0; m_ones = 0;
        end else begin
            bit nd;
            nd = 0;
            if (abort) begin
                m_active = 0;
            end else if (m_active) begin
                if (out_ready) begin
                    acc_q.push_back(m_beats[m_pos]);
                    m_ones += pop8(m_beats[m_pos]);
                    if (m_pos == NB - 1) begin
                        m_active = 0;
                        nd = 1;
                    end else begin
                        m_pos++;
                    end
                end
            end else if (start) begin
                m_active = 1;
                m_pos = 0;
                m_ones = 0;
                for (int k = 0; k < NB; k++) m_beats[k] = beat_ref(matrix_in, k);
            end
            m_done = nd;
        end
    end

    always @(negedge clk) begin
        chk("valid", out_valid, m_active);
        chk("busy", busy, m_active);
        chk("done", done, m_done);
        chk("ones_count", ones_count, exp_ones());
        if (m_active) begin
            chk("data", out_data, m_beats[m_pos]);
            chk("index", out_index, m_pos);
            chk("last", out_last, m_pos == NB - 1);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (done) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: no done pulse within 40 cycles", name);
        end
    endtask

    task automatic chk_frame(input string name, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2);
        chk({name, "_nbeats"}, acc_q.size(), NB);
        if (acc_q.size() == NB) begin
            chk({name, "_b0"}, acc_q[0], b0);
            chk({name, "_b1"}, acc_q[1], b1);
            chk({name, "_b2"}, acc_q[2], b2);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, dcnt, lcnt, to;
        reset_n = 0; start = 0; abort = 0; out_ready = 0; matrix_in = '0;
        repeat (2) cyc();
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        chk("rst_index", out_index, 0);
        chk("rst_ones", ones_count, 0);
        reset_n = 1;
        cyc();

        // All-ones matrix, zero-wait sink.
        acc_q.delete();
        matrix_in = 20'hFFFFF; start = 1; out_ready = 1;
        cyc();
        start = 0;
        chk("s1_first_data", out_data, 8'hFF);
        chk("s1_first_index", out_index, 0);
        wait_done("s1", n);
        chk("s1_done_latency", n, 3);
        chk_frame("s1", 8'hFF, 8'hFF, 8'h0F);
`ifdef EDA_OUT_READER_COUNT_EN
        chk("s1_ones", ones_count, 20);
`else
        chk("s1_ones", ones_count, 0);
`endif

        // Stalling sink, ready pattern 1,0,0.
        acc_q.delete();
        matrix_in = 20'hA5C3E; start = 1;
        cyc();
        start = 0;
        to = 1;
        for (int i = 0; i < 40; i++) begin
            out_ready = (i % 3 == 0);
            cyc();
            if (done) begin to = 0; break; end
        end
        chk("s2_timeout", to, 0);
        chk_frame("s2", 8'h3E, 8'h5C, 8'h0A);

        // Input changes after the snapshot are not seen.
        acc_q.delete();
        out_ready = 1; matrix_in = 20'h12345; start = 1;
        cyc();
        start = 0; matrix_in = '0;
        wait_done("s3", n);
        chk_frame("s3", 8'h45, 8'h23, 8'h01);

        // Abort after beat 0 is accepted.
        matrix_in = 20'h0F0F0; start = 1;
        cyc();
        start = 0;
        cyc();
        chk("s4_index_before_abort", out_index, 1);
        abort = 1;
        cyc();
        abort = 0;
        chk("s4_valid_after_abort", out_valid, 0);
        chk("s4_busy_after_abort", busy, 0);
        cyc();
        chk("s4_no_done", done, 0);
        start = 1;
        cyc();
        start = 0;
        chk("s4_restart_index", out_index, 0);
        wait_done("s4", n);

        // Asynchronous reset during beat 1.
        matrix_in = 20'hFFFFF; start = 1;
        cyc();
        start = 0;
        cyc();
        #2 reset_n = 0;
        #1;
        chk("s5_valid", out_valid, 0);
        chk("s5_data", out_data, 0);
        chk("s5_index", out_index, 0);
        chk("s5_last", out_last, 0);
        chk("s5_busy", busy, 0);
        chk("s5_ones", ones_count, 0);
        cyc();
        reset_n = 1;
        repeat (3) cyc();
        chk("s5_idle_after_reset", out_valid, 0);

        // start held high: back-to-back frames.
        matrix_in = 20'h9B3D1; start = 1; out_ready = 1;
        dcnt = 0; lcnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (done) dcnt++;
            if (out_valid && out_last) lcnt++;
        end
        start = 0;
        chk("s6_done_pulses", dcnt, 3);
        chk("s6_last_beats", lcnt, 3);
        repeat (2) cyc();

        // Randomised frames with random ready, stray starts and aborts.
        for (int f = 0; f < 40; f++) begin
            matrix_in = 20'($urandom); start = 1;
            cyc();
            start = 0;
            to = 1;
            for (int i = 0; i < 60; i++) begin
                out_ready = 1'($urandom_range(0, 1));
                abort = ($urandom_range(0, 19) == 0);
                start = ($urandom_range(0, 7) == 0);
                matrix_in = 20'($urandom);
                cyc();
                abort = 0; start = 0;
                if (!m_active) begin to = 0; break; end
            end
            if (to != 0) chk("rand_timeout", to, 0);
        end
        out_ready = 1;
        repeat (6) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/eda_output_reader.md
# eda_output_reader

Streams the M×N regional-maximum flag matrix out of the output RAM over a valid/ready interface, BEAT_WIDTH bits per beat, row-major. On `start` it snapshots the whole matrix into an internal register, so the RAM can be cleared for the next image while streaming continues. It sits between the output RAM and the host/DMA interface, and is the read side of the RAM's write/clear path.

## Interface
- M, `CFG_M, number of matrix rows
- N, `CFG_N, number of matrix columns
- BEAT_WIDTH, 8, bits per output beat (1..M*N)
- NUM_BEATS, derived, ceil(M*N/BEAT_WIDTH)
- BEAT_IDX_W, derived, max(1, $clog2(NUM_BEATS))
- CNT_W, derived, $clog2(M*N+1)

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  snapshot `matrix_in` and begin streaming; ignored unless in IDLE
- abort  in  1  synchronous; terminates streaming and returns to IDLE
- matrix_in  in  M*N  flag matrix; bit i*N+j is pixel (i,j)
- out_valid  out  1  beat available
- out_ready  in  1  sink accepts beat
- out_data  out  BEAT_WIDTH  beat payload
- out_last  out  1  marks the final beat
- out_index  out  BEAT_IDX_W  index of the current beat, 0..NUM_BEATS-1
- busy  out  1  high in STREAM
- done  out  1  one-cycle pulse after the last beat is accepted
- ones_count  out  CNT_W  number of 1-flags streamed (see Configuration)

## Operation
- FSM states are IDLE and STREAM. Reset state is IDLE.
- IDLE → STREAM: on `start`, the snapshot register loads `matrix_in`, the beat counter is set to 0 and `ones_count` is set to 0.
- In STREAM:
  - out_data[t] = snapshot bit (out_index*BEAT_WIDTH + t) when that index is < M*N; otherwise 0 (last-beat zero padding).
  - out_last = (out_index == NUM_BEATS-1).
- A handshake is `out_valid && out_ready`.
  - On a non-last handshake, out_index increments.
  - On the last handshake, the FSM returns to IDLE and `done` pulses in the next cycle.
- Stall: while `out_valid && !out_ready`, out_data, out_index and out_last hold stable.
- `matrix_in` changes after the snapshot have no effect on the current stream.
- abort: in any state, the FSM goes to IDLE at the next edge.
  - out_valid drops.
  - No `done` pulse is generated.
  - ones_count holds its partial value.
  - abort has priority over start and over a concurrent handshake.
- `start` while in STREAM is ignored. `start` in the same cycle as the `done` pulse (FSM already in IDLE) is accepted.
- Reset values:
  - out_valid, out_last, busy, done = 0
  - out_data, out_index, ones_count = 0
  - snapshot = all 1s, matching the RAM's cleared state
- Reset asserted mid-stream forces the reset values immediately (asynchronous). No beat is completed.

## Timing
- `start` sampled high at edge E0 → out_valid=1, out_index=0 from E0.
- Zero-wait sink: one beat per cycle. With out_ready held high, the last beat is accepted at edge E0+NUM_BEATS.
- `done` is high for the cycle following the last-beat handshake edge. busy falls at that same edge.
- Minimum gap from one `start` to the next is NUM_BEATS+1 cycles.
- out_valid never deasserts without a handshake, except on abort or reset.
- All outputs are registered; there is no combinational path from out_ready to out_valid or out_data.

## Configuration
- Macro `EDA_OUT_READER_COUNT_EN`.
  - Defined: ones_count accumulates the popcount of each accepted beat, padding excluded. After `done` it equals the total number of 1-flags in the snapshot, and it holds until the next `start`.
  - Undefined: ones_count is tied to 0 and no popcount logic is synthesized. All other behaviour is identical.

## Test plan
All scenarios use M=4, N=5, BEAT_WIDTH=8, so NUM_BEATS=3.
- Reset then start, matrix_in=20'hFFFFF, out_ready=1 → beats 8'hFF, 8'hFF, 8'h0F. out_last on beat 2. done pulses one cycle after beat 2. ones_count=20 (macro defined) or 0 (undefined).
- matrix_in=20'hA5C3E, out_ready toggling 1,0,0,1,… → beats 8'h3E, 8'h5C, 8'h0A. Each beat is held stable across stalls.
- start, then change matrix_in to 0 one cycle later → stream still carries the original snapshot values.
- abort asserted after beat 0 is accepted → out_valid=0 next cycle. No done pulse. busy=0. A new start restarts at out_index=0.
- reset_n pulsed low during beat 1 → all outputs 0 immediately. After release the FSM is in IDLE and ignores out_ready.
- start held high continuously, ready=1 → back-to-back frames of exactly 3 beats each. The start pulses seen during STREAM are ignored. done pulses once per frame.
